// File: rtl/tproc_isa_pkg.sv
// Shared ISA constants, opcode field helper and issue-sequencer state encoding.
package tproc_isa_pkg;

    localparam int INSTR_W = 64;
    localparam int OPC_HI  = 63;
    localparam int OPC_LO  = 56;

    localparam logic [7:0] OPC_NOP        = 8'h00;
    localparam logic [7:0] OPC_FETCH_A    = 8'h01;
    localparam logic [7:0] OPC_FETCH_B    = 8'h02;
    localparam logic [7:0] OPC_FETCH_ADDR = 8'h04;
    localparam logic [7:0] OPC_HALT       = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_DECODE,
        S_ISSUE,
        S_WAIT_EXEC,
        S_DONE
    } issue_state_t;

    function automatic logic [7:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instr_prefetch_buf.sv
// One-entry prefetch buffer: an RD_LAT delay line marks when a speculative read returns.
// Compiled only when INSTR_ISSUE_PREFETCH_EN is defined.
`ifdef INSTR_ISSUE_PREFETCH_EN
module instr_prefetch_buf
    import tproc_isa_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               rd_issue,
    input  logic [INSTR_W-1:0] rd_data,
    input  logic               consume,
    output logic               valid,
    output logic [INSTR_W-1:0] data
);

    logic [RD_LAT-1:0] dly;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            dly   <= '0;
            valid <= 1'b0;
        end else begin
            dly <= (dly << 1) | RD_LAT'(rd_issue);
            if (dly[RD_LAT-1]) begin
                valid <= 1'b1;
            end else if (consume) begin
                valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dly[RD_LAT-1]) begin
            data <= rd_data;
        end
    end

endmodule
`endif

// File: rtl/instruction_issue.sv
// Instruction sequencer: fetches words from instruction RAM, skips NOPs, stops on HALT,
// and issues each word to the decoder, waiting for exec_done. Option: INSTR_ISSUE_PREFETCH_EN.
module instruction_issue
    import tproc_isa_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [CNT_W-1:0]   instr_count,
    output logic               instr_rd_en,
    output logic [ADDR_W-1:0]  instr_rd_addr,
    input  logic [INSTR_W-1:0] instr_rd_data,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_enable,
    input  logic               exec_done,
    output logic               busy,
    output logic               finished,
    output logic [ADDR_W-1:0]  pc
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    issue_state_t       state, state_n;
    logic [ADDR_W-1:0]  pc_n;
    logic [CNT_W-1:0]   remaining, rem_n;
    logic [LAT_W-1:0]   wcnt, wcnt_n;
    logic [INSTR_W-1:0] word, word_n;
    logic [INSTR_W-1:0] instr_n;
    logic [7:0]         opc;

    assign opc = opcode_of(word);

`ifdef INSTR_ISSUE_PREFETCH_EN
    logic               pf_req, pf_req_n;
    logic               exec_seen, seen_n;
    logic               pf_consume, pf_clear;
    logic               pf_valid;
    logic [INSTR_W-1:0] pf_data;

    instr_prefetch_buf #(
        .RD_LAT (RD_LAT)
    ) u_pf (
        .clk      (clk),
        .rst      (rst),
        .clear    (pf_clear),
        .rd_issue (pf_req),
        .rd_data  (instr_rd_data),
        .consume  (pf_consume),
        .valid    (pf_valid),
        .data     (pf_data)
    );

    assign instr_rd_en   = (state == S_FETCH) || pf_req;
    assign instr_rd_addr = pf_req ? pc + ADDR_W'(1) : pc;
`else
    assign instr_rd_en   = (state == S_FETCH);
    assign instr_rd_addr = pc;
`endif

    assign instr_enable = (state == S_ISSUE);
    assign busy         = (state != S_IDLE);
    assign finished     = (state == S_DONE);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        rem_n   = remaining;
        wcnt_n  = wcnt;
        word_n  = word;
        instr_n = instruction;
`ifdef INSTR_ISSUE_PREFETCH_EN
        pf_req_n   = 1'b0;
        seen_n     = exec_seen;
        pf_consume = 1'b0;
        pf_clear   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
`ifdef INSTR_ISSUE_PREFETCH_EN
                pf_clear = 1'b1;
                seen_n   = 1'b0;
`endif
                if (start) begin
                    if (instr_count == '0) begin
                        state_n = S_DONE;
                    end else begin
                        pc_n    = base_addr;
                        rem_n   = instr_count;
                        state_n = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                wcnt_n  = '0;
                state_n = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (wcnt == LAT_W'(RD_LAT - 1)) begin
                    word_n  = instr_rd_data;
                    state_n = S_DECODE;
                end else begin
                    wcnt_n = wcnt + LAT_W'(1);
                end
            end
            S_DECODE: begin
                if (opc == OPC_HALT) begin
                    state_n = S_DONE;
                end else if (opc == OPC_NOP) begin
                    pc_n    = pc + ADDR_W'(1);
                    rem_n   = remaining - CNT_W'(1);
                    state_n = (remaining == CNT_W'(1)) ? S_DONE : S_FETCH;
                end else begin
                    instr_n = word;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT_EXEC;
`ifdef INSTR_ISSUE_PREFETCH_EN
                pf_req_n = (remaining > CNT_W'(1));
                seen_n   = 1'b0;
`endif
            end
            S_WAIT_EXEC: begin
`ifdef INSTR_ISSUE_PREFETCH_EN
                // exec_seen: execution finished but the prefetched word is still in flight
                if (exec_seen) begin
                    if (pf_valid) begin
                        word_n     = pf_data;
                        pf_consume = 1'b1;
                        seen_n     = 1'b0;
                        state_n    = S_DECODE;
                    end
                end else if (exec_done) begin
                    pc_n  = pc + ADDR_W'(1);
                    rem_n = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_n = S_DONE;
                    end else if (pf_valid) begin
                        word_n     = pf_data;
                        pf_consume = 1'b1;
                        state_n    = S_DECODE;
                    end else begin
                        seen_n = 1'b1;
                    end
                end
`else
                if (exec_done) begin
                    pc_n    = pc + ADDR_W'(1);
                    rem_n   = remaining - CNT_W'(1);
                    state_n = (remaining == CNT_W'(1)) ? S_DONE : S_FETCH;
                end
`endif
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            remaining   <= '0;
            wcnt        <= '0;
            instruction <= '0;
`ifdef INSTR_ISSUE_PREFETCH_EN
            pf_req      <= 1'b0;
            exec_seen   <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            remaining   <= rem_n;
            wcnt        <= wcnt_n;
            instruction <= instr_n;
`ifdef INSTR_ISSUE_PREFETCH_EN
            pf_req      <= pf_req_n;
            exec_seen   <= seen_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        word <= word_n;
    end

endmodule

// File: tb/tb_instruction_issue.sv
// Scoreboard bench for instruction_issue: expected reads/issues queued by stimulus, checked by a monitor.
module tb_instruction_issue;
    import tproc_isa_pkg::*;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;
    localparam int RD_LAT = 2;
`ifdef INSTR_ISSUE_PREFETCH_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 3 + RD_LAT;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  base_addr = '0;
    logic [CNT_W-1:0]   instr_count = '0;
    logic               instr_rd_en;
    logic [ADDR_W-1:0]  instr_rd_addr;
    logic [INSTR_W-1:0] instr_rd_data;
    logic [INSTR_W-1:0] instruction;
    logic               instr_enable;
    logic               exec_done;
    logic               busy;
    logic               finished;
    logic [ADDR_W-1:0]  pc;

    always #5 clk = ~clk;

    instruction_issue #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .instr_count   (instr_count),
        .instr_rd_en   (instr_rd_en),
        .instr_rd_addr (instr_rd_addr),
        .instr_rd_data (instr_rd_data),
        .instruction   (instruction),
        .instr_enable  (instr_enable),
        .exec_done     (exec_done),
        .busy          (busy),
        .finished      (finished),
        .pc            (pc)
    );

    // Instruction RAM with RD_LAT-cycle read pipeline
    logic [INSTR_W-1:0] mem [0:65535];
    logic [INSTR_W-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (instr_rd_en) rd_pipe[0] <= mem[instr_rd_addr];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign instr_rd_data = rd_pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard queues
    logic [63:0]       exp_word_q[$];
    logic [ADDR_W-1:0] exp_pc_q[$];
    logic [ADDR_W-1:0] exp_rd_q[$];
    int                issue_cyc[$];
    int                exec_cyc[$];
    int                fin_count = 0;
    int                last_fin_cyc = 0;

    task automatic push_issue(input logic [ADDR_W-1:0] a, input logic [63:0] w);
        exp_pc_q.push_back(a);
        exp_word_q.push_back(w);
    endtask

    always @(negedge clk) begin
        if (instr_rd_en) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got read of %h, expected no read", instr_rd_addr);
            end else begin
                check("rd_addr", instr_rd_addr, exp_rd_q.pop_front());
            end
        end
        if (instr_enable) begin
            issue_cyc.push_back(cyc);
            if (exp_word_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: got %h at pc %h, expected no issue", instruction, pc);
            end else begin
                check("issue_word", instruction, exp_word_q.pop_front());
                check("issue_pc", pc, exp_pc_q.pop_front());
            end
        end
        if (finished) begin
            fin_count++;
            last_fin_cyc = cyc;
        end
    end

    // Execution unit model: exec_done exec_delay cycles after each issue
    int   ed_cnt = 0;
    int   exec_delay = 5;
    bit   auto_exec = 1'b1;
    bit   issue_pulse = 1'b0;
    logic auto_p = 1'b0;
    logic force_exec = 1'b0;
    assign exec_done = auto_p | force_exec;

    always @(negedge clk) begin
        auto_p = 1'b0;
        if (ed_cnt > 0) begin
            ed_cnt--;
            if (ed_cnt == 0) begin
                auto_p = 1'b1;
                exec_cyc.push_back(cyc);
            end
        end
        if (instr_enable && auto_exec) begin
            ed_cnt = exec_delay;
            if (issue_pulse) auto_p = 1'b1;
        end
    end

    int start_cyc = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
        @(negedge clk);
        base_addr   = b;
        instr_count = n;
        start       = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input string name, input int target);
        int t;
        t = 0;
        while (fin_count < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        tick(3);
        check({name, "_finished"}, fin_count, target);
        check({name, "_busy_after"}, busy, 1'b0);
        check({name, "_issues_left"}, exp_word_q.size(), 0);
        check({name, "_reads_left"}, exp_rd_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc, n0, t, e0, i0;
        logic [63:0] w;

        mem[16'h0010] = {OPC_FETCH_A,    56'h11_2233_4455_6677};
        mem[16'h0011] = {OPC_FETCH_B,    56'h88_99AA_BBCC_DDEE};
        mem[16'h0012] = {OPC_FETCH_ADDR, 56'h01_0203_0405_0607};
        mem[16'h0018] = {OPC_FETCH_B,    56'hA0_A1A2_A3A4_A5A6};
        mem[16'h0019] = {OPC_NOP,        56'hDE_AD00_BEEF_0000};
        mem[16'h001A] = {OPC_FETCH_ADDR, 56'hB0_B1B2_B3B4_B5B6};
        mem[16'h001B] = {OPC_FETCH_A,    56'hC0_C1C2_C3C4_C5C6};
        mem[16'h0020] = {OPC_FETCH_A,    56'h20_2020_2020_2020};
        mem[16'h0021] = {OPC_HALT,       56'h00_0000_0000_0000};
        mem[16'h0022] = {OPC_FETCH_B,    56'h22_2222_2222_2222};
        mem[16'hFFFF] = {OPC_FETCH_B,    56'hFF_FFFF_FFFF_FFFF};
        mem[16'h0000] = {OPC_FETCH_A,    56'h00_0000_0000_0001};
        mem[16'h0030] = {OPC_FETCH_ADDR, 56'h30_3030_3030_3030};
        mem[16'h0031] = {OPC_FETCH_A,    56'h31_3131_3131_3131};
        mem[16'h0060] = {OPC_FETCH_B,    56'h60_6060_6060_6060};

        // Reset state
        tick(3);
        check("rst_rd_en", instr_rd_en, 1'b0);
        check("rst_rd_addr", instr_rd_addr, 16'h0000);
        check("rst_instruction", instruction, 64'h0);
        check("rst_instr_enable", instr_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_finished", finished, 1'b0);
        check("rst_pc", pc, 16'h0000);
        rst = 1'b0;
        tick(2);

        // Three plain instructions
        exp_rd_q.push_back(16'h0010);
        exp_rd_q.push_back(16'h0011);
        exp_rd_q.push_back(16'h0012);
        push_issue(16'h0010, mem[16'h0010]);
        push_issue(16'h0011, mem[16'h0011]);
        push_issue(16'h0012, mem[16'h0012]);
        launch(16'h0010, 16'd3);
        check("t1_busy_running", busy, 1'b1);
        finish_run("t1", 1);

        // NOP consumed without issue
        exp_rd_q.push_back(16'h0018);
        exp_rd_q.push_back(16'h0019);
        exp_rd_q.push_back(16'h001A);
        exp_rd_q.push_back(16'h001B);
        push_issue(16'h0018, mem[16'h0018]);
        push_issue(16'h001A, mem[16'h001A]);
        push_issue(16'h001B, mem[16'h001B]);
        launch(16'h0018, 16'd4);
        finish_run("t2a", 2);

        // HALT ends the program early, no further reads
        exp_rd_q.push_back(16'h0020);
        exp_rd_q.push_back(16'h0021);
        push_issue(16'h0020, mem[16'h0020]);
        launch(16'h0020, 16'd4);
        finish_run("t2b", 3);

        // Zero-length program: start sampled, DONE on the following cycle
        launch(16'h0040, 16'd0);
        finish_run("t3", 4);
        check("t3_fin_delay", last_fin_cyc - start_cyc, 1);

        // pc wraps from 0xFFFF to 0x0000
        exp_rd_q.push_back(16'hFFFF);
        exp_rd_q.push_back(16'h0000);
        push_issue(16'hFFFF, mem[16'hFFFF]);
        push_issue(16'h0000, mem[16'h0000]);
        launch(16'hFFFF, 16'd2);
        finish_run("t4", 5);

        // Reset during WAIT_EXEC together with exec_done
        auto_exec = 1'b0;
        exp_rd_q.push_back(16'h0060);
        push_issue(16'h0060, mem[16'h0060]);
        n0 = issue_cyc.size();
        launch(16'h0060, 16'd1);
        t = 0;
        while (issue_cyc.size() == n0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t5_issue_seen", issue_cyc.size(), n0 + 1);
        tick(1);
        fc = fin_count;
        rst = 1'b1;
        force_exec = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force_exec = 1'b0;
        check("t5_rd_en", instr_rd_en, 1'b0);
        check("t5_rd_addr", instr_rd_addr, 16'h0000);
        check("t5_instruction", instruction, 64'h0);
        check("t5_instr_enable", instr_enable, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_finished", finished, 1'b0);
        check("t5_pc", pc, 16'h0000);
        tick(4);
        check("t5_no_finished", fin_count, fc);
        auto_exec = 1'b1;
        exp_rd_q.push_back(16'h0060);
        push_issue(16'h0060, mem[16'h0060]);
        launch(16'h0060, 16'd1);
        finish_run("t5_replay", fc + 1);

        // exec_done in ISSUE cycle and start while busy are ignored; issue latency
        issue_pulse = 1'b1;
        exp_rd_q.push_back(16'h0030);
        exp_rd_q.push_back(16'h0031);
        push_issue(16'h0030, mem[16'h0030]);
        push_issue(16'h0031, mem[16'h0031]);
        i0 = issue_cyc.size();
        e0 = exec_cyc.size();
        fc = fin_count;
        launch(16'h0030, 16'd2);
        tick(3);
        base_addr   = 16'h0050;
        instr_count = 16'd1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run("t6", fc + 1);
        issue_pulse = 1'b0;
        if (issue_cyc.size() >= i0 + 2 && exec_cyc.size() >= e0 + 1) begin
            check("t6_exec_to_issue", issue_cyc[i0+1] - exec_cyc[e0], EXP_LAT);
        end else begin
            checks++;
            errors++;
            $display("FAIL t6_events: got %0d issues %0d exec pulses, expected 2 and at least 1",
                     issue_cyc.size() - i0, exec_cyc.size() - e0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
